// File: rtl/uart_regbank.sv
// UART register bank: CSR map plus TX push / RX pop with a bounded wait; `UART_REGBANK_INTR_STAT_EN adds a sticky INTR_STAT.
// Latency: mack_o one cycle after mreq_i when resolvable, at most WAIT_LIMIT+1 cycles for TX/RX data accesses.
// Backpressure: request held until mack_o; stalls on tx_data_ready_i/rx_data_valid_i and times out with mresp_o=1.
module uart_regbank #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INTR   = 4,
   parameter int WAIT_LIMIT = 15
) (
   input  logic                    clk_i,
   input  logic                    arst_ni,
   input  logic                    mreq_i,
   input  logic [ADDR_WIDTH-1:0]   maddr_i,
   input  logic                    mwe_i,
   input  logic [DATA_WIDTH-1:0]   mwdata_i,
   input  logic [DATA_WIDTH/8-1:0] mstrb_i,
   output logic                    mack_o,
   output logic [DATA_WIDTH-1:0]   mrdata_o,
   output logic                    mresp_o,
   output logic [DATA_WIDTH-1:0]   ctrl_o,
   output logic [DATA_WIDTH-1:0]   clk_div_o,
   output logic [DATA_WIDTH-1:0]   cfg_o,
   output logic [DATA_WIDTH-1:0]   intr_ctrl_o,
   input  logic [DATA_WIDTH-1:0]   tx_fifo_count_i,
   input  logic [DATA_WIDTH-1:0]   rx_fifo_count_i,
   output logic [DATA_WIDTH-1:0]   tx_data_o,
   output logic                    tx_data_valid_o,
   input  logic                    tx_data_ready_i,
   input  logic [DATA_WIDTH-1:0]   rx_data_i,
   input  logic                    rx_data_valid_i,
   output logic                    rx_data_ready_o,
   input  logic [NUM_INTR-1:0]     intr_event_i,
   output logic                    intr_o
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = $clog2(WAIT_LIMIT + 1);

   localparam logic [ADDR_WIDTH-1:0] A_CTRL      = ADDR_WIDTH'(8'h00);
   localparam logic [ADDR_WIDTH-1:0] A_CLK_DIV   = ADDR_WIDTH'(8'h04);
   localparam logic [ADDR_WIDTH-1:0] A_CFG       = ADDR_WIDTH'(8'h08);
   localparam logic [ADDR_WIDTH-1:0] A_TX_CNT    = ADDR_WIDTH'(8'h0C);
   localparam logic [ADDR_WIDTH-1:0] A_RX_CNT    = ADDR_WIDTH'(8'h10);
   localparam logic [ADDR_WIDTH-1:0] A_TX_DATA   = ADDR_WIDTH'(8'h14);
   localparam logic [ADDR_WIDTH-1:0] A_RX_DATA   = ADDR_WIDTH'(8'h18);
   localparam logic [ADDR_WIDTH-1:0] A_INTR_CTRL = ADDR_WIDTH'(8'h1C);
`ifdef UART_REGBANK_INTR_STAT_EN
   localparam logic [ADDR_WIDTH-1:0] A_INTR_STAT = ADDR_WIDTH'(8'h20);
`endif

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state;
   logic [CNT_W-1:0]      wait_cnt;
   logic [CNT_W-1:0]      cnt_nxt;
   logic                  pend_tx;
   logic                  busy;
   logic                  dec_err;
   logic                  dec_tx;
   logic                  dec_rx;
   logic                  dec_stall;
   logic                  partner_rdy;
   logic [DATA_WIDTH-1:0] dec_rdata;
   logic [DATA_WIDTH-1:0] wmask;

`ifdef UART_REGBANK_INTR_STAT_EN
   logic [NUM_INTR-1:0]   intr_stat;
   logic [NUM_INTR-1:0]   stat_clr;
`endif

   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_v,
                                                   input logic [DATA_WIDTH-1:0] new_v,
                                                   input logic [DATA_WIDTH-1:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   always_comb begin
      wmask = '0;
      for (int b = 0; b < STRB_W; b++) wmask[b*8 +: 8] = {8{mstrb_i[b]}};
   end

   // Decode of the live request; only consulted while in IDLE.
   always_comb begin
      dec_err   = 1'b0;
      dec_tx    = 1'b0;
      dec_rx    = 1'b0;
      dec_rdata = '0;
      busy      = (tx_fifo_count_i != '0) || (rx_fifo_count_i != '0);
      case (maddr_i)
         A_CTRL:      dec_rdata = ctrl_o;
         A_CLK_DIV:   begin dec_rdata = clk_div_o; dec_err = mwe_i && busy; end
         A_CFG:       begin dec_rdata = cfg_o;     dec_err = mwe_i && busy; end
         A_TX_CNT:    begin dec_rdata = tx_fifo_count_i; dec_err = mwe_i; end
         A_RX_CNT:    begin dec_rdata = rx_fifo_count_i; dec_err = mwe_i; end
         A_TX_DATA:   begin dec_err = !mwe_i; dec_tx = mwe_i; end
         A_RX_DATA:   begin dec_err = mwe_i; dec_rx = !mwe_i; dec_rdata = rx_data_i; end
         A_INTR_CTRL: dec_rdata = intr_ctrl_o;
`ifdef UART_REGBANK_INTR_STAT_EN
         A_INTR_STAT: dec_rdata[NUM_INTR-1:0] = intr_stat;
`endif
         default:     dec_err = 1'b1;
      endcase
   end

   assign dec_stall   = (dec_tx && !tx_data_ready_i) || (dec_rx && !rx_data_valid_i);
   assign partner_rdy = pend_tx ? tx_data_ready_i : rx_data_valid_i;
   assign cnt_nxt     = wait_cnt + CNT_W'(1);

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state           <= S_IDLE;
         wait_cnt        <= '0;
         pend_tx         <= 1'b0;
         mack_o          <= 1'b0;
         mresp_o         <= 1'b0;
         mrdata_o        <= '0;
         ctrl_o          <= '0;
         clk_div_o       <= DATA_WIDTH'(16'h2580);
         cfg_o           <= '0;
         intr_ctrl_o     <= '0;
         tx_data_o       <= '0;
         tx_data_valid_o <= 1'b0;
         rx_data_ready_o <= 1'b0;
      end else begin
         mack_o          <= 1'b0;
         mresp_o         <= 1'b0;
         mrdata_o        <= '0;
         tx_data_valid_o <= 1'b0;
         rx_data_ready_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mreq_i) begin
                  wait_cnt <= '0;
                  if (dec_stall) begin
                     state   <= S_WAIT;
                     pend_tx <= dec_tx;
                  end else begin
                     state   <= S_RESP;
                     mack_o  <= 1'b1;
                     mresp_o <= dec_err;
                     if (!mwe_i && !dec_err) mrdata_o <= dec_rdata;
                     if (dec_tx) begin
                        tx_data_valid_o <= 1'b1;
                        tx_data_o       <= mwdata_i;
                     end
                     if (dec_rx) rx_data_ready_o <= 1'b1;
                     if (mwe_i && !dec_err) begin
                        case (maddr_i)
                           A_CTRL:      ctrl_o      <= merge(ctrl_o, mwdata_i, wmask);
                           A_CLK_DIV:   clk_div_o   <= merge(clk_div_o, mwdata_i, wmask);
                           A_CFG:       cfg_o       <= merge(cfg_o, mwdata_i, wmask);
                           A_INTR_CTRL: intr_ctrl_o <= merge(intr_ctrl_o, mwdata_i, wmask);
                           default: ;
                        endcase
                     end
                  end
               end
            end
            S_WAIT: begin
               wait_cnt <= cnt_nxt;
               // Partner readiness wins over a timeout landing in the same cycle.
               if (partner_rdy) begin
                  state  <= S_RESP;
                  mack_o <= 1'b1;
                  if (pend_tx) begin
                     tx_data_valid_o <= 1'b1;
                     tx_data_o       <= mwdata_i;
                  end else begin
                     rx_data_ready_o <= 1'b1;
                     mrdata_o        <= rx_data_i;
                  end
               end else if (cnt_nxt == CNT_W'(WAIT_LIMIT)) begin
                  state   <= S_RESP;
                  mack_o  <= 1'b1;
                  mresp_o <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef UART_REGBANK_INTR_STAT_EN
   assign stat_clr = (state == S_IDLE && mreq_i && mwe_i && maddr_i == A_INTR_STAT)
                     ? (mwdata_i[NUM_INTR-1:0] & wmask[NUM_INTR-1:0]) : '0;

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         intr_stat <= '0;
         intr_o    <= 1'b0;
      end else begin
         intr_stat <= (intr_stat & ~stat_clr) | intr_event_i;
         intr_o    <= |(intr_stat & intr_ctrl_o[NUM_INTR-1:0]);
      end
   end
`else
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) intr_o <= 1'b0;
      else          intr_o <= |(intr_event_i & intr_ctrl_o[NUM_INTR-1:0]);
   end
`endif

endmodule

// File: doc/uart_regbank.md
UART_REGBANK -- requirements
Module: uart_regbank

Interface
REQ-001 Parameter ADDR_WIDTH, default 6: byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32: bus and register width, multiple of 8.
REQ-003 Parameter NUM_INTR, default 4: interrupt event count, 1..DATA_WIDTH.
REQ-004 Parameter WAIT_LIMIT, default 15: maximum wait cycles for a TX/RX data access, at least 1.
REQ-005 Ports (name direction width meaning):
 clk_i in 1 global clock
 arst_ni in 1 asynchronous active-low reset
 mreq_i in 1 request, held until mack_o
 maddr_i in ADDR_WIDTH byte address
 mwe_i in 1 write when 1
 mwdata_i in DATA_WIDTH write data
 mstrb_i in DATA_WIDTH/8 byte strobes
 mack_o out 1 one-cycle acknowledge
 mrdata_o out DATA_WIDTH read data, valid with mack_o
 mresp_o out 1 error, valid with mack_o
 ctrl_o, clk_div_o, cfg_o, intr_ctrl_o out DATA_WIDTH configuration registers
 tx_fifo_count_i, rx_fifo_count_i in DATA_WIDTH FIFO occupancy
 tx_data_o out DATA_WIDTH, tx_data_valid_o out 1, tx_data_ready_i in 1: TX push
 rx_data_i in DATA_WIDTH, rx_data_valid_i in 1, rx_data_ready_o out 1: RX pop
 intr_event_i in NUM_INTR one-cycle event pulses
 intr_o out 1 interrupt request

Function
REQ-006 Map: CTRL 0x00 RW, CLK_DIV 0x04 RW, CFG 0x08 RW, TX_FIFO_COUNT 0x0C RO, RX_FIFO_COUNT 0x10 RO, TX_DATA 0x14 WO, RX_DATA 0x18 RO, INTR_CTRL 0x1C RW, INTR_STAT 0x20 RW1C; other addresses are errors.
REQ-007 FSM states IDLE, WAIT, RESP; IDLE->RESP when mreq_i and the access is resolvable; IDLE->WAIT for TX_DATA write with tx_data_ready_i=0 or RX_DATA read with rx_data_valid_i=0.
REQ-008 WAIT: wait counter increments each cycle; ->RESP when the partner becomes ready (ok) or the counter reaches WAIT_LIMIT (mresp_o=1, no transfer).
REQ-009 RESP: mack_o=1 for exactly one cycle, mrdata_o/mresp_o registered; next state IDLE; minimum latency is 1 cycle from mreq_i to mack_o.
REQ-010 tx_data_valid_o and rx_data_ready_o pulse for exactly one cycle, in the cycle the FSM leaves IDLE/WAIT with ok status; at most one pulse per transaction.
REQ-011 tx_data_o = mwdata_i, captured when tx_data_valid_o is asserted.
REQ-012 RW writes update only bytes whose mstrb_i bit is 1; mstrb_i=0 writes succeed with no change.
REQ-013 CLK_DIV and CFG writes with tx_fifo_count_i or rx_fifo_count_i nonzero: error, register unchanged.
REQ-014 Writes to RO registers and reads of TX_DATA: error, no side effects.
REQ-015 Reads of RW registers return the current value; unused bits read 0.
REQ-016 Inputs are sampled when leaving IDLE/WAIT; later changes to maddr_i/mwe_i do not affect the transaction in flight.

Reset
REQ-017 On arst_ni=0, regardless of clock: FSM IDLE, wait counter 0, ctrl_o 0, clk_div_o 0x2580, cfg_o 0, intr_ctrl_o 0, INTR_STAT 0, mack_o/mresp_o/mrdata_o 0, tx_data_valid_o/rx_data_ready_o 0, intr_o 0.
REQ-018 A reset during WAIT aborts the transaction: no ack and no data pulse after reset is released.

Configuration
REQ-019 Macro UART_REGBANK_INTR_STAT_EN defined: INTR_STAT[i] is set by intr_event_i[i] and cleared by writing 1 with strobe; on a simultaneous set and clear, set wins; intr_o is registered as OR(INTR_STAT & intr_ctrl_o[NUM_INTR-1:0]).
REQ-020 Macro undefined: INTR_STAT is absent and address 0x20 is an error; intr_o = OR(intr_event_i & intr_ctrl_o[NUM_INTR-1:0]) registered, one-cycle pulses only.

Verification
REQ-021 Reset, then read CLK_DIV -> mack_o one cycle after mreq_i, mrdata_o=0x2580, mresp_o=0.
REQ-022 Write CTRL 0xAABBCCDD with mstrb_i=0b0101 over 0 -> ctrl_o=0x00BB00DD.
REQ-023 Write TX_DATA 0x41 with tx_data_ready_i=0, raised after 3 cycles -> a single tx_data_valid_o pulse with tx_data_o=0x41, mresp_o=0; ready held low for 15 cycles -> mresp_o=1 and no pulse.
REQ-024 Write CFG while rx_fifo_count_i=2 -> mresp_o=1, cfg_o unchanged; repeat with both counts 0 -> ok.
REQ-025 (INTR_STAT_EN) intr_ctrl_o=0x1, pulse intr_event_i[0] -> INTR_STAT=0x1, intr_o=1; write 0x1 to INTR_STAT in the same cycle as a new event -> bit stays 1.
REQ-026 Assert arst_ni=0 during WAIT for RX_DATA -> all outputs 0 and no mack_o after release.
